// File: rtl/cnn_core_scheduler.sv
// CNN core scheduler: queues job tags, dispatches them round-robin to free
// cores, captures core results and presents them round-robin to a consumer.
module cnn_core_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int ID_W      = 4,
  parameter int QDEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid,
  input  logic [ID_W-1:0]           job_id,
  output logic                      job_ready,
  output logic [NUM_CORES-1:0]      core_enable,
  input  logic [NUM_CORES-1:0]      core_done,
  input  logic [32*NUM_CORES-1:0]   core_value,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [31:0]               res_value,
  input  logic                      res_ready,
  output logic                      idle,
  output logic                      err
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef enum logic [1:0] {
    CORE_FREE   = 2'd0,
    CORE_BUSY   = 2'd1,
    CORE_RESULT = 2'd2
  } core_state_e;

  core_state_e         core_state_r   [NUM_CORES];
  core_state_e         core_state_nxt_s [NUM_CORES];
  logic [ID_W-1:0]     tag_r          [NUM_CORES];
  logic [31:0]         val_r          [NUM_CORES];
  logic [ID_W-1:0]     fifo_mem_r     [QDEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         count_r;
  logic [PW-1:0]       disp_ptr_r;
  logic [PW-1:0]       res_ptr_r;
  logic                err_r;

  logic                fifo_empty_s;
  logic                push_s;
  logic                disp_found_s;
  logic [PW-1:0]       disp_idx_s;
  logic                dispatch_s;
  logic                res_found_s;
  logic [PW-1:0]       res_idx_s;
  logic                res_fire_s;
  logic                spur_s;
  logic                all_free_s;

  // Round-robin pointer increment wrapping at NUM_CORES.
  function automatic logic [PW-1:0] core_inc(input logic [PW-1:0] p);
    if (p == PW'(NUM_CORES - 1)) return {PW{1'b0}};
    else                          return p + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  // FIFO pointer increment wrapping at QDEPTH.
  function automatic logic [AW-1:0] fifo_inc(input logic [AW-1:0] p);
    if (p == AW'(QDEPTH - 1)) return {AW{1'b0}};
    else                       return p + {{(AW-1){1'b0}}, 1'b1};
  endfunction

  assign fifo_empty_s = (count_r == {(AW+1){1'b0}});
  assign job_ready    = (count_r < (AW+1)'(QDEPTH));
  assign push_s       = job_valid && job_ready;
  assign dispatch_s   = disp_found_s && !fifo_empty_s;
  assign res_fire_s   = res_found_s && res_ready;
  assign err          = err_r;

  // Dispatch search: first FREE core at or after the dispatch pointer.
  always_comb begin
    disp_found_s = 1'b0;
    disp_idx_s   = {PW{1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!disp_found_s && core_state_r[(int'(disp_ptr_r) + i) % NUM_CORES] == CORE_FREE) begin
        disp_found_s = 1'b1;
        disp_idx_s   = PW'((int'(disp_ptr_r) + i) % NUM_CORES);
      end else begin
        disp_found_s = disp_found_s;
      end
    end
  end

  // Result search: first RESULT core at or after the result pointer.
  always_comb begin
    res_found_s = 1'b0;
    res_idx_s   = {PW{1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!res_found_s && core_state_r[(int'(res_ptr_r) + i) % NUM_CORES] == CORE_RESULT) begin
        res_found_s = 1'b1;
        res_idx_s   = PW'((int'(res_ptr_r) + i) % NUM_CORES);
      end else begin
        res_found_s = res_found_s;
      end
    end
  end

  // Per-core next state, spurious-done detection and all-free summary.
  always_comb begin
    spur_s     = 1'b0;
    all_free_s = 1'b1;
    for (int k = 0; k < NUM_CORES; k++) begin
      core_state_nxt_s[k] = core_state_r[k];
      if (core_done[k] && core_state_r[k] != CORE_BUSY) spur_s = 1'b1;
      else                                              spur_s = spur_s;
      if (core_state_r[k] != CORE_FREE) all_free_s = 1'b0;
      else                              all_free_s = all_free_s;
      case (core_state_r[k])
        CORE_FREE: begin
          if (dispatch_s && disp_idx_s == PW'(k)) core_state_nxt_s[k] = CORE_BUSY;
          else                                   core_state_nxt_s[k] = CORE_FREE;
        end
        CORE_BUSY: begin
          if (core_done[k]) core_state_nxt_s[k] = CORE_RESULT;
          else              core_state_nxt_s[k] = CORE_BUSY;
        end
        CORE_RESULT: begin
          if (res_fire_s && res_idx_s == PW'(k)) core_state_nxt_s[k] = CORE_FREE;
          else                                  core_state_nxt_s[k] = CORE_RESULT;
        end
        default: core_state_nxt_s[k] = CORE_FREE;
      endcase
    end
  end

  // Output decode from registered state only; no input-to-output paths.
  always_comb begin
    core_enable = {NUM_CORES{1'b0}};
    if (dispatch_s) core_enable[disp_idx_s] = 1'b1;
    else            core_enable = {NUM_CORES{1'b0}};
    res_valid = res_found_s;
    if (res_found_s) begin
      res_id    = tag_r[res_idx_s];
      res_value = val_r[res_idx_s];
    end else begin
      res_id    = {ID_W{1'b0}};
      res_value = 32'd0;
    end
    idle = fifo_empty_s && all_free_s;
  end

  // Core state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CORES; k++) core_state_r[k] <= CORE_FREE;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) core_state_r[k] <= core_state_nxt_s[k];
    end
  end

  // Job FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) fifo_mem_r[i] <= {ID_W{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= job_id;
        wr_ptr_r             <= fifo_inc(wr_ptr_r);
      end
      if (dispatch_s) rd_ptr_r <= fifo_inc(rd_ptr_r);
      case ({push_s, dispatch_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Round-robin pointers; a stalled result pins the result pointer to its
  // core so a newly finished core cannot displace the presented result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_ptr_r <= {PW{1'b0}};
      res_ptr_r  <= {PW{1'b0}};
    end else begin
      if (dispatch_s) disp_ptr_r <= core_inc(disp_idx_s);
      if (res_fire_s)       res_ptr_r <= core_inc(res_idx_s);
      else if (res_found_s) res_ptr_r <= res_idx_s;
    end
  end

  // Per-core tag capture on dispatch and result capture on done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        tag_r[k] <= {ID_W{1'b0}};
        val_r[k] <= 32'd0;
      end
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (dispatch_s && disp_idx_s == PW'(k)) tag_r[k] <= fifo_mem_r[rd_ptr_r];
        if (core_done[k] && core_state_r[k] == CORE_BUSY) val_r[k] <= core_value[32*k +: 32];
      end
    end
  end

  // Sticky protocol-error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_r <= 1'b0;
    else      err_r <= err_r | spur_s;
  end

endmodule

// File: tb/tb_cnn_core_scheduler.sv
// Directed self-checking bench for cnn_core_scheduler (4 cores, 4-bit ids,
// 4-deep queue). Inputs change and outputs are sampled on the falling edge.
module tb_cnn_core_scheduler;

  logic         clk;
  logic         rst;
  logic         job_valid;
  logic [3:0]   job_id;
  logic         job_ready;
  logic [3:0]   core_enable;
  logic [3:0]   core_done;
  logic [127:0] core_value;
  logic         res_valid;
  logic [3:0]   res_id;
  logic [31:0]  res_value;
  logic         res_ready;
  logic         idle;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  cnn_core_scheduler #(.NUM_CORES(4), .ID_W(4), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_id(job_id), .job_ready(job_ready),
    .core_enable(core_enable), .core_done(core_done), .core_value(core_value),
    .res_valid(res_valid), .res_id(res_id), .res_value(res_value), .res_ready(res_ready),
    .idle(idle), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; job_valid = 1'b0; job_id = 4'd0; core_done = 4'd0;
    core_value = 128'd0; res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; job_valid = 1'b0; job_id = 4'd0; core_done = 4'd0;
    core_value = 128'd0; res_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (core_enable !== 4'b0000) begin n_bad++; $display("FAIL reset_enable: got %b expected 0000", core_enable); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    n_cmp++; if (res_id !== 4'd0 || res_value !== 32'd0) begin n_bad++; $display("FAIL reset_res_data: got %h/%h expected 0/0", res_id, res_value); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (job_ready !== 1'b1 || idle !== 1'b1) begin n_bad++; $display("FAIL reset_ready_idle: got %b/%b expected 1/1", job_ready, idle); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_job();
    do_reset();
    res_ready = 1'b1;
    job_valid = 1'b1; job_id = 4'd3;
    tick();
    job_valid = 1'b0;
    n_cmp++; if (core_enable !== 4'b0001) begin n_bad++; $display("FAIL single_enable: got %b expected 0001", core_enable); end
    tick();
    n_cmp++; if (core_enable !== 4'b0000) begin n_bad++; $display("FAIL single_enable_pulse: got %b expected 0000", core_enable); end
    tick();
    core_done = 4'b0001; core_value[31:0] = 32'h0000_0042;
    tick();
    core_done = 4'b0000;
    n_cmp++; if (res_valid !== 1'b1 || res_id !== 4'd3 || res_value !== 32'h42) begin n_bad++; $display("FAIL single_result: got v=%b id=%h val=%h expected 1/3/42", res_valid, res_id, res_value); end
    tick();
    n_cmp++; if (res_valid !== 1'b0 || idle !== 1'b1) begin n_bad++; $display("FAIL single_idle: got v=%b idle=%b expected 0/1", res_valid, idle); end
  endtask

  task automatic test_fill();
    logic [3:0] exp_en;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      job_valid = 1'b1; job_id = 4'(i);
      tick();
      exp_en = (i < 4) ? (4'b0001 << i) : 4'b0000;
      n_cmp++; if (core_enable !== exp_en) begin n_bad++; $display("FAIL fill_enable[%0d]: got %b expected %b", i, core_enable, exp_en); end
    end
    job_valid = 1'b0;
    n_cmp++; if (job_ready !== 1'b0 || idle !== 1'b0) begin n_bad++; $display("FAIL fill_full: got ready=%b idle=%b expected 0/0", job_ready, idle); end
    core_done = 4'b1111;
    for (int k = 0; k < 4; k++) core_value[32*k +: 32] = 32'(100 + k);
    tick();
    core_done = 4'b0000;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (res_valid !== 1'b1 || res_id !== 4'(k) || res_value !== 32'(100 + k)) begin n_bad++; $display("FAIL fill_result[%0d]: got v=%b id=%h val=%0d expected 1/%0d/%0d", k, res_valid, res_id, res_value, k, 100 + k); end
      if (k > 0) begin
        exp_en = 4'b0001 << (k - 1);
        n_cmp++; if (core_enable !== exp_en) begin n_bad++; $display("FAIL fill_redispatch[%0d]: got %b expected %b", k, core_enable, exp_en); end
      end
      tick();
    end
  endtask

  task automatic test_simul_done();
    do_reset();
    res_ready = 1'b1;
    job_valid = 1'b1; job_id = 4'hA; tick();
    job_id = 4'hB; tick();
    job_id = 4'hC; tick();
    job_valid = 1'b0;
    tick();
    core_done = 4'b0110;
    core_value[63:32] = 32'd11; core_value[95:64] = 32'd22;
    tick();
    core_done = 4'b0000;
    n_cmp++; if (res_valid !== 1'b1 || res_id !== 4'hB || res_value !== 32'd11) begin n_bad++; $display("FAIL simul_first: got v=%b id=%h val=%0d expected 1/b/11", res_valid, res_id, res_value); end
    tick();
    n_cmp++; if (res_valid !== 1'b1 || res_id !== 4'hC || res_value !== 32'd22) begin n_bad++; $display("FAIL simul_second: got v=%b id=%h val=%0d expected 1/c/22", res_valid, res_id, res_value); end
    tick();
    n_cmp++; if (res_valid !== 1'b0 || idle !== 1'b0) begin n_bad++; $display("FAIL simul_drained: got v=%b idle=%b expected 0/0", res_valid, idle); end
    core_done = 4'b0001; core_value[31:0] = 32'd5;
    tick();
    core_done = 4'b0000;
    n_cmp++; if (res_id !== 4'hA || res_value !== 32'd5) begin n_bad++; $display("FAIL simul_core0: got id=%h val=%0d expected a/5", res_id, res_value); end
    tick();
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL simul_idle: got %b expected 1", idle); end
  endtask

  task automatic test_backpressure();
    do_reset();
    res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      job_valid = 1'b1; job_id = 4'(i);
      tick();
    end
    job_valid = 1'b0;
    core_done = 4'b0010; core_value[63:32] = 32'h77;
    tick();
    core_done = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (res_valid !== 1'b1 || res_id !== 4'd2 || res_value !== 32'h77) begin n_bad++; $display("FAIL bp_stable[%0d]: got v=%b id=%h val=%h expected 1/2/77", i, res_valid, res_id, res_value); end
      n_cmp++; if (core_enable !== 4'b0000) begin n_bad++; $display("FAIL bp_no_dispatch[%0d]: got %b expected 0000", i, core_enable); end
      core_done = (i == 1) ? 4'b0001 : 4'b0000;
      core_value[31:0] = 32'h55;
      tick();
      core_done = 4'b0000;
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++; if (core_enable !== 4'b0010) begin n_bad++; $display("FAIL bp_redispatch: got %b expected 0010", core_enable); end
    n_cmp++; if (res_valid !== 1'b1 || res_id !== 4'd1 || res_value !== 32'h55) begin n_bad++; $display("FAIL bp_next_result: got v=%b id=%h val=%h expected 1/1/55", res_valid, res_id, res_value); end
  endtask

  task automatic test_spurious();
    do_reset();
    core_done = 4'b0100;
    tick();
    core_done = 4'b0000;
    n_cmp++; if (err !== 1'b1 || res_valid !== 1'b0) begin n_bad++; $display("FAIL spur_err: got err=%b v=%b expected 1/0", err, res_valid); end
    tick(); tick(); tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL spur_sticky: got %b expected 1", err); end
    rst = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL spur_clear: got %b expected 0", err); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_midrun_reset();
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      job_valid = 1'b1; job_id = 4'(i + 8);
      tick();
    end
    job_valid = 1'b0;
    core_done = 4'b1100; core_value[95:64] = 32'd7; core_value[127:96] = 32'd9;
    tick();
    core_done = 4'b0000;
    n_cmp++; if (res_valid !== 1'b1 || res_id !== 4'd10 || idle !== 1'b0) begin n_bad++; $display("FAIL mid_pre: got v=%b id=%h idle=%b expected 1/a/0", res_valid, res_id, idle); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (core_enable !== 4'b0000 || res_valid !== 1'b0 || res_id !== 4'd0 || res_value !== 32'd0) begin n_bad++; $display("FAIL mid_reset_outs: got en=%b v=%b id=%h val=%h expected 0/0/0/0", core_enable, res_valid, res_id, res_value); end
    n_cmp++; if (job_ready !== 1'b1 || idle !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags: got ready=%b idle=%b err=%b expected 1/1/0", job_ready, idle, err); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (idle !== 1'b1 || core_enable !== 4'b0000) begin n_bad++; $display("FAIL mid_release_idle: got idle=%b en=%b expected 1/0000", idle, core_enable); end
    core_done = 4'b0001;
    tick();
    core_done = 4'b0000;
    n_cmp++; if (err !== 1'b1 || res_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale_done: got err=%b v=%b expected 1/0", err, res_valid); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_fill();
    test_simul_done();
    test_backpressure();
    test_spurious();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnn_core_scheduler.md
CNN_CORE_SCHEDULER -- requirements
Module: cnn_core_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of CNN cores served.
REQ-002 SHALL have parameter ID_W, default 4, job tag width.
REQ-003 SHALL have parameter QDEPTH, default 4, job queue depth (power of two).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port job_valid  input  1  job request present.
REQ-007 SHALL have port job_id  input  ID_W  job tag.
REQ-008 SHALL have port job_ready  output  1  queue can accept a job.
REQ-009 SHALL have port core_enable  output  NUM_CORES  one-cycle start pulse per core.
REQ-010 SHALL have port core_done  input  NUM_CORES  one-cycle completion pulse per core.
REQ-011 SHALL have port core_value  input  32*NUM_CORES  core result; core k occupies bits [32k+31:32k].
REQ-012 SHALL have port res_valid  output  1  result available.
REQ-013 SHALL have port res_id  output  ID_W  tag of the presented result.
REQ-014 SHALL have port res_value  output  32  presented result value.
REQ-015 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-016 SHALL have port idle  output  1  queue empty, all cores free, no pending results.
REQ-017 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-018 SHALL accept a job on a cycle with job_valid and job_ready both high, writing job_id into a QDEPTH-entry FIFO.
REQ-019 SHALL drive job_ready = (FIFO count < QDEPTH); a push while full does not occur by construction.
REQ-020 SHALL hold a per-core state: FREE, BUSY, or RESULT (done, result not yet delivered).
REQ-021 SHALL, each cycle the FIFO is non-empty and at least one core is FREE, pop the head job, pulse core_enable[k] high for exactly one cycle for the selected FREE core k, store its tag, and move k to BUSY.
REQ-022 SHALL select the dispatch core round-robin: search starts at dispatch pointer, first FREE core wins, pointer becomes k+1 mod NUM_CORES; at most one dispatch per cycle.
REQ-023 SHALL give minimum latency of one cycle from job acceptance to core_enable (job accepted at edge N, core_enable high during cycle N+1).
REQ-024 SHALL, on core_done[k] with core k BUSY, capture core_value slice k and move k to RESULT on that edge.
REQ-025 SHALL handle multiple core_done bits in the same cycle, capturing all of them.
REQ-026 SHALL ignore core_done[k] when core k is not BUSY and set err, which stays high until reset.
REQ-027 SHALL present results from RESULT cores round-robin via a separate result pointer: res_valid high, with res_id/res_value from the selected core.
REQ-028 SHALL keep res_id/res_value stable while res_valid is high and res_ready is low.
REQ-029 SHALL, on res_valid and res_ready both high, return the selected core to FREE and advance the result pointer to k+1 mod NUM_CORES.
REQ-030 SHALL allow a core freed by result acceptance to be dispatched no earlier than the next cycle.
REQ-031 SHALL allow same-cycle FIFO push and pop, keeping the count unchanged.
REQ-032 SHALL allow same-cycle dispatch to one core, done capture on another, and result accept on a third.
REQ-033 SHALL give one-cycle done-to-result latency: core_done at edge M, res_valid high in cycle M+1 if no older result is pending.
REQ-034 SHALL wrap FIFO pointers modulo QDEPTH.

Reset
REQ-035 SHALL, on rst low, immediately clear the FIFO, set all cores FREE, zero both round-robin pointers, and force core_enable=0, res_valid=0, res_id=0, res_value=0, err=0, job_ready=1, idle=1.
REQ-036 SHALL, on reset asserted mid-operation, discard queued jobs, in-flight tags and captured results; core_done arriving in the cycle after release is an error per REQ-026.

Verification
REQ-037 SHALL pass this single-job test: push id=3; core_done[0] with core_value=0x0000_0042 three cycles later; res_ready=1 -> core_enable=0001 one cycle after push; res_valid with id=3, value=0x42 one cycle after done; idle=1 afterwards.
REQ-038 SHALL pass this fill test: push 8 jobs (ids 0-7) back-to-back with cores never done -> cores 0,1,2,3 enabled in consecutive cycles with ids 0-3; ids 4-7 fill the FIFO; job_ready=0 with 4 queued.
REQ-039 SHALL pass this simultaneous-done test: cores 1 and 2 done in the same cycle with values 11 and 22 and res_ready=1 -> results delivered on consecutive cycles in order 11 then 22; both cores then FREE.
REQ-040 SHALL pass this backpressure test: hold res_ready=0 for 5 cycles with a pending result -> res_id/res_value stable and the core not re-dispatched; release -> result accepted, core dispatched the following cycle if a job is queued.
REQ-041 SHALL pass this spurious-done test: core_done[2] while core 2 is FREE -> err=1, no res_valid, err stays high until rst low.
REQ-042 SHALL pass this mid-run reset test: reset asserted with 2 cores BUSY and 3 jobs queued -> all outputs at reset values immediately; idle=1 after release.
